// File: rtl/moxie_wb_arbiter.sv
// Two-master Wishbone arbiter for the moxie core: instruction fetch (M0)
// and data (M1) share one slave port, with a no-ack watchdog.
module moxie_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int RR      = 0,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state;
    logic          last;
    logic [WW-1:0] wdog;
    logic [1:0]    gnt;
    logic          g0;
    logic          g1;
    logic          x_cyc;
    logic          x_stb;

    assign g0    = (state == GNT0);
    assign g1    = (state == GNT1);
    assign x_cyc = g1 ? m1_cyc_i : m0_cyc_i;
    assign x_stb = g1 ? m1_stb_i : m0_stb_i;

    assign s_adr_o = g1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = g1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = g1 ? m1_we_i  : m0_we_i;
    assign s_cyc_o = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign s_stb_o = (g0 & m0_stb_i) | (g1 & m1_stb_i);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = g0 & s_ack_i;
    assign m1_ack_o = g1 & s_ack_i;
    // In ERR the pointer already names the master that timed out
    assign m0_err_o = (state == ERR) & ~last;
    assign m1_err_o = (state == ERR) & last;
    assign gnt_o    = gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            gnt   <= 2'b00;
            wdog  <= '0;
            last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    wdog <= '0;
                    unique case (1'b1)
                        (m0_cyc_i && m1_cyc_i): begin
                            if (RR != 0 && last) begin
                                state <= GNT0;
                                gnt   <= 2'b01;
                            end else begin
                                state <= GNT1;
                                gnt   <= 2'b10;
                            end
                        end
                        (m1_cyc_i && !m0_cyc_i): begin
                            state <= GNT1;
                            gnt   <= 2'b10;
                        end
                        (m0_cyc_i && !m1_cyc_i): begin
                            state <= GNT0;
                            gnt   <= 2'b01;
                        end
                        default: ;
                    endcase
                end
                GNT0, GNT1: begin
                    if (!x_cyc) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
                        wdog  <= '0;
                        last  <= g1;
                    end else if (s_ack_i || !x_stb) begin
                        wdog <= '0;
                    end else if (TIMEOUT != 0) begin
                        if (wdog == WW'(TIMEOUT)) begin
                            state <= ERR;
                            gnt   <= 2'b00;
                            wdog  <= '0;
                            last  <= g1;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                end
                ERR: begin
                    state <= IDLE;
                    wdog  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Bench for moxie_wb_arbiter: fixed-priority instance (a) and
// round-robin instance (b) share stimulus, both with an 8-cycle watchdog.
module tb_moxie_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack;

    logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
    logic [3:0]  a_s_sel;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
    logic        a_s_we, a_s_cyc, a_s_stb;
    logic [1:0]  a_gnt;

    logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
    logic [3:0]  b_s_sel;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic        b_s_we, b_s_cyc, b_s_stb;
    logic [1:0]  b_gnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] dq[$];
    logic [1:0]  gq[$];

    always #5 clk = ~clk;

    moxie_wb_arbiter #(.RR(0), .TIMEOUT(8)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel),
        .s_we_o(a_s_we), .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(a_gnt)
    );

    moxie_wb_arbiter #(.RR(1), .TIMEOUT(8)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel),
        .s_we_o(b_s_we), .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(b_gnt)
    );

    task automatic release_all();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        m0_adr = '0; m0_dat = '0; m0_sel = 4'hf; m0_we = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = 4'hf; m1_we = 1'b0;
        s_dat  = '0;
        release_all();
        repeat (3) @(negedge clk);
        checks++;
        if (a_gnt !== 2'b00 || b_gnt !== 2'b00) begin
            $display("FAIL reset_gnt got %b/%b want 00", a_gnt, b_gnt);
            errors++;
        end
        checks++;
        if (a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 || a_m0_err !== 1'b0 || a_m1_err !== 1'b0) begin
            $display("FAIL reset_ctl got cyc=%b stb=%b err=%b%b want 0", a_s_cyc, a_s_stb, a_m1_err, a_m0_err);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_m0_read();
        logic [31:0] exp;
        m0_adr = 32'h1000; m0_cyc = 1'b1; m0_stb = 1'b1;
        dq.push_back(32'hDEADBEEF);
        #1;
        checks++;
        if (a_s_cyc !== 1'b0) begin
            $display("FAIL idle_no_cyc got %b want 0", a_s_cyc);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (a_s_cyc !== 1'b1 || a_gnt !== 2'b01 || a_s_adr !== 32'h1000) begin
            $display("FAIL m0_grant got cyc=%b gnt=%b adr=%h want 1 01 1000", a_s_cyc, a_gnt, a_s_adr);
            errors++;
        end
        s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) begin
            $display("FAIL m0_ack got m0=%b m1=%b want 1 0", a_m0_ack, a_m1_ack);
            errors++;
        end else if (dq.size() > 0) begin
            exp = dq.pop_front();
            checks++;
            if (a_m0_dat !== exp) begin
                $display("FAIL m0_rdata got %h want %h", a_m0_dat, exp);
                errors++;
            end
        end
        @(negedge clk);
        release_all();
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b00 || a_s_cyc !== 1'b0) begin
            $display("FAIL m0_release got gnt=%b cyc=%b want 00 0", a_gnt, a_s_cyc);
            errors++;
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp;
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        m0_adr = 32'h100; m1_adr = 32'h200;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        exp = gq.pop_front();
        checks++;
        if (a_gnt !== exp || a_s_adr !== 32'h200) begin
            $display("FAIL prio_first got gnt=%b adr=%h want %b 200", a_gnt, a_s_adr, exp);
            errors++;
        end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b00 || a_s_cyc !== 1'b0) begin
            $display("FAIL prio_bubble got gnt=%b cyc=%b want 00 0", a_gnt, a_s_cyc);
            errors++;
        end
        @(negedge clk);
        exp = gq.pop_front();
        checks++;
        if (a_gnt !== exp || a_s_adr !== 32'h100) begin
            $display("FAIL prio_second got gnt=%b adr=%h want %b 100", a_gnt, a_s_adr, exp);
            errors++;
        end
        release_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        int n;
        gq.push_back(2'b10); gq.push_back(2'b01);
        gq.push_back(2'b10); gq.push_back(2'b01);
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            @(negedge clk);
            while (b_gnt == 2'b00 && n < 10) begin
                @(negedge clk);
                n++;
            end
            exp = gq.pop_front();
            checks++;
            if (b_gnt !== exp || n != 0) begin
                $display("FAIL rr_grant%0d got gnt=%b wait=%0d want %b 0", t, b_gnt, n, exp);
                errors++;
            end
            if (b_gnt[1]) begin
                m1_cyc = 1'b0; m1_stb = 1'b0;
            end else begin
                m0_cyc = 1'b0; m0_stb = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (b_gnt !== 2'b00) begin
                $display("FAIL rr_bubble%0d got %b want 00", t, b_gnt);
                errors++;
            end
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        end
        release_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        m1_adr = 32'h300; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b10) begin
            $display("FAIL to_grant got %b want 10", a_gnt);
            errors++;
        end
        n = 0;
        while (a_m1_err !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_m1_err !== 1'b1 || n != 9) begin
            $display("FAIL to_latency got err=%b after %0d want 1 after 9", a_m1_err, n);
            errors++;
        end
        checks++;
        if (a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 || a_m0_err !== 1'b0) begin
            $display("FAIL to_err_cycle got cyc=%b stb=%b m0_err=%b want 0 0 0", a_s_cyc, a_s_stb, a_m0_err);
            errors++;
        end
        s_ack = 1'b1;
        #1;
        checks++;
        if (a_m1_ack !== 1'b0) begin
            $display("FAIL to_late_ack_err got %b want 0", a_m1_ack);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (a_m1_err !== 1'b0 || a_m1_ack !== 1'b0 || a_gnt !== 2'b00) begin
            $display("FAIL to_after got err=%b ack=%b gnt=%b want 0 0 00", a_m1_err, a_m1_ack, a_gnt);
            errors++;
        end
        release_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        m1_adr = 32'h400; m1_cyc = 1'b1; m1_stb = 1'b1;
        m0_adr = 32'h500;
        @(negedge clk);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_gnt !== 2'b10) begin
                $display("FAIL b2b_hold%0d got %b want 10", i, a_gnt);
                errors++;
            end
            s_ack = 1'b1;
            s_dat = 32'hA5A50000 + 32'(i * 17);
            dq.push_back(32'hA5A50000 + 32'(i * 17));
            #1;
            checks++;
            if (a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0) begin
                $display("FAIL b2b_ack%0d got m1=%b m0=%b want 1 0", i, a_m1_ack, a_m0_ack);
                errors++;
            end else if (dq.size() > 0) begin
                exp = dq.pop_front();
                checks++;
                if (a_m1_dat !== exp) begin
                    $display("FAIL b2b_data%0d got %h want %h", i, a_m1_dat, exp);
                    errors++;
                end
            end
            @(negedge clk);
        end
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b00 || a_m0_ack !== 1'b0) begin
            $display("FAIL b2b_bubble got gnt=%b ack=%b want 00 0", a_gnt, a_m0_ack);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b01 || a_s_adr !== 32'h500) begin
            $display("FAIL b2b_m0 got gnt=%b adr=%h want 01 500", a_gnt, a_s_adr);
            errors++;
        end
        release_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b01) begin
            $display("FAIL rst_mid_grant got %b want 01", a_gnt);
            errors++;
        end
        rst_n = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (a_gnt !== 2'b00 || a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 ||
            a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0 || a_m0_err !== 1'b0 || a_m1_err !== 1'b0) begin
            $display("FAIL rst_mid got gnt=%b cyc=%b stb=%b ack=%b%b err=%b%b want all 0",
                     a_gnt, a_s_cyc, a_s_stb, a_m1_ack, a_m0_ack, a_m1_err, a_m0_err);
            errors++;
        end
        rst_n = 1'b1;
        release_all();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moxie_wb_arbiter.md
Name: moxie_wb_arbiter

Overview:
- Shares one Wishbone slave port (unified memory/peripheral bus) between the core's instruction-fetch master (M0) and data master (M1).
- Grants the bus per cycle-transaction: the grant is held from request until the master drops cyc.
- Priority is fixed or round-robin; a timeout watchdog converts a missing slave ack into an error response.
- Sits between the moxie core's wb_I_*/wb_D_* ports and the system bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- SW, 4, byte-select width (DW/8).
- RR, 0, 0 = fixed priority (M1 data wins), 1 = round-robin.
- TIMEOUT, 255, cycles with stb asserted and no ack before error; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- m0_adr_i  in  AW  instruction master address.
- m0_dat_i  in  DW  instruction master write data.
- m0_sel_i  in  SW  instruction master byte select.
- m0_we_i  in  1  instruction master write enable.
- m0_cyc_i  in  1  instruction master cycle.
- m0_stb_i  in  1  instruction master strobe.
- m0_dat_o  out  DW  read data to M0.
- m0_ack_o  out  1  ack to M0.
- m0_err_o  out  1  timeout error to M0.
- m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i  in  AW/DW/SW/1/1/1  data master, same meanings as M0.
- m1_dat_o  out  DW  read data to M1.
- m1_ack_o  out  1  ack to M1.
- m1_err_o  out  1  timeout error to M1.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  SW  slave byte select.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  2  one-hot current grant {M1,M0}, for debug/perf.

Behaviour:
- Reset: rst_n_i low at a clock edge forces state IDLE, gnt_o=0, watchdog=0, last-grant pointer=M0.
  - All s_cyc_o/s_stb_o/ack/err outputs low in the same cycle (combinational gating by state).
  - Reset mid-transaction abandons it with no ack or err.
- States: IDLE, GNT0, GNT1, ERR.
- IDLE:
  - If only one mX_cyc_i is high, go to GNTX.
  - If both: with RR=0 go to GNT1; with RR=1 grant the master not equal to the last-grant pointer.
  - Grant latency is 1 cycle; slave signals are never driven in IDLE.
- GNTX:
  - s_adr/dat/sel/we_o = mX inputs.
  - s_cyc_o = mX_cyc_i; s_stb_o = mX_stb_i.
  - mX_ack_o = s_ack_i; mX_dat_o = s_dat_i.
  - Other master's ack/err = 0; both mX_dat_o always carry s_dat_i.
  - Multiple stb/ack beats are allowed within one grant.
  - When mX_cyc_i drops, go to IDLE and set last-grant pointer = X.
  - Always one IDLE bubble between grants; a newly raised request from the other master never pre-empts.
- Watchdog (TIMEOUT>0):
  - Counts up while in GNTX with s_stb_o=1 and s_ack_i=0; cleared on s_ack_i, on leaving GNTX, or when stb is low.
  - When the count reaches TIMEOUT, go to ERR.
- ERR: mX_err_o=1 for exactly one cycle; s_cyc_o=s_stb_o=0; then IDLE, pointer=X.
- s_ack_i arriving in ERR or IDLE is ignored and not forwarded.
- Ack and timeout on the same cycle: the ack wins and the counter clears.
- Fixed-priority mode can starve M0; this is accepted because the core stalls fetch during data access.

Test Plan:
- Reset, then M0 cyc/stb with adr=0x1000 and slave acking 1 cycle later with dat=0xDEADBEEF -> s_cyc_o high the cycle after request; m0_ack_o=1 and m0_dat_o=0xDEADBEEF; m1_ack_o=0; gnt_o=01.
- M0 and M1 request in the same cycle with RR=0 -> gnt_o=10 and M1's address appears on s_adr_o; after M1 drops cyc, one IDLE cycle, then gnt_o=01.
- RR=1, both masters request continuously, 4 transactions -> grants alternate M1,M0,M1,M0 (pointer=M0 after reset); one bubble between each.
- TIMEOUT=8, M1 strobes and slave never acks -> m1_err_o pulses exactly once, 9 cycles after grant; s_cyc_o low that cycle; next state IDLE; late s_ack_i not forwarded.
- M1 holds cyc for 3 ack beats while M0 requests -> no pre-emption; M0 is granted 2 cycles after M1 drops cyc.
- rst_n_i low mid-transaction with ack pending -> next cycle all s_/m_ control outputs 0 and gnt_o=0; no ack or err emitted.
